// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared loader state encodings, word geometry and lane helper
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] WORD_STRIDE    = 32'd4;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0000;

    // Big-endian lane: byte index 0 lands in [31:24], index 3 in [7:0].
    function automatic int lane_lsb(input logic [1:0] idx);
        return 8 * (BYTES_PER_WORD - 1 - int'(idx));
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, memory write port and status bundle of the loader
interface imem_loader_if #(
    parameter int CNT_W = 9
);
    logic             start;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_last;
    logic             byte_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             busy;
    logic             done;
    logic             overflow;
    logic             cpu_hold;
    logic [CNT_W-1:0] word_count;

    modport master (
        output start, byte_valid, byte_data, byte_last,
        input  byte_ready, mem_we, mem_addr, mem_wdata,
               busy, done, overflow, cpu_hold, word_count
    );

    modport slave (
        input  start, byte_valid, byte_data, byte_last,
        output byte_ready, mem_we, mem_addr, mem_wdata,
               busy, done, overflow, cpu_hold, word_count
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - big-endian byte-to-word packer with lane index and clear
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word <= NOP_WORD;
            idx  <= 2'd0;
        end else if (clear) begin
            word <= NOP_WORD;
            idx  <= 2'd0;
        end else if (load) begin
            word[lane_lsb(idx) +: 8] <= byte_data;
            idx                      <= idx + 2'd1;
        end
    end

    // Asserted in the cycle whose load fills the last lane.
    assign full = load && (idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a byte stream into words and writes instruction memory, holding the CPU until done
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256,
    parameter int          CNT_W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    loader_state_t state;
    logic          last_seen;
    logic          xfer;
    logic          at_cap;
    logic          load;
    logic          restart;
    logic          clear;
    logic          full;
    logic [31:0]   word;

    // byte_ready is only ever high in COLLECT, so a transfer implies COLLECT.
    assign xfer    = bus.byte_valid && bus.byte_ready;
    assign at_cap  = (bus.word_count == CNT_W'(DEPTH));
    assign load    = xfer && !at_cap;
    assign restart = bus.start &&
                     (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign clear   = restart || (state == ST_WRITE);

    assign bus.mem_wdata = word;

    imem_loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .load      (load),
        .byte_data (bus.byte_data),
        .word      (word),
        .full      (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            last_seen      <= 1'b0;
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= BASE_ADDR;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.cpu_hold   <= 1'b1;
            bus.word_count <= '0;
        end else if (restart) begin
            state          <= ST_COLLECT;
            last_seen      <= 1'b0;
            bus.byte_ready <= 1'b1;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= BASE_ADDR;
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
            bus.overflow   <= 1'b0;
            bus.cpu_hold   <= 1'b1;
            bus.word_count <= '0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (xfer && at_cap) begin
                        // Memory is full: swallow the byte and park in ERR.
                        state          <= ST_ERR;
                        bus.overflow   <= 1'b1;
                        bus.byte_ready <= 1'b0;
                        bus.busy       <= 1'b0;
                    end else if (load && (full || bus.byte_last)) begin
                        state          <= ST_WRITE;
                        last_seen      <= bus.byte_last;
                        bus.byte_ready <= 1'b0;
                        bus.mem_we     <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    bus.mem_we     <= 1'b0;
                    bus.mem_addr   <= bus.mem_addr + WORD_STRIDE;
                    bus.word_count <= bus.word_count + CNT_W'(1);
                    if (last_seen) begin
                        state        <= ST_DONE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.cpu_hold <= 1'b0;
                    end else begin
                        state          <= ST_COLLECT;
                        bus.byte_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule
